// File: rtl/merge_arb_pkg.sv
// Shared types and two-rail constants for the merge arbiter.
// Each data bit travels on a pair of rails, so every bit is one of four rail codes.
package merge_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    RTZ  = 2'd2
  } state_t;

  localparam int RAIL_NUM = 2;

  localparam logic [1:0] NULL = 2'b00;
  localparam logic [1:0] D0   = 2'b01;
  localparam logic [1:0] D1   = 2'b10;
  localparam logic [1:0] ILL  = 2'b11;

  // True when a rail pair carries a valid logic value
  function automatic logic rail_is_data(input logic [1:0] r);
    return (r == D0) || (r == D1);
  endfunction

endpackage

// File: rtl/merge_arb_if.sv
// Bundle of two requesters, the shared consumer, and the error flag around merge_arb.
// The slave modport is the arbiter's view; the master modport is the surrounding environment.
interface merge_arb_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0][1:0] in0;
  logic [WIDTH-1:0][1:0] in1;
  logic [WIDTH-1:0][1:0] out;
  logic                  ack_o0;
  logic                  ack_o1;
  logic                  ack_i;
  logic                  err;

  modport master (
    output in0, in1, ack_i,
    input  out, ack_o0, ack_o1, err
  );

  modport slave (
    input  in0, in1, ack_i,
    output out, ack_o0, ack_o1, err
  );
endinterface

// File: rtl/merge_arb_dr_stat.sv
// Combinational status of one two-rail word.
// It reports complete (all bits valid), null (all bits empty) and illegal (any 11 pair).
module dr_stat
  import merge_arb_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0][1:0] din,
  output logic                  complete,
  output logic                  is_null,
  output logic                  illegal
);

  always_comb begin
    complete = 1'b1;
    is_null  = 1'b1;
    illegal  = 1'b0;
    for (int b = 0; b < WIDTH; b++) begin
      if (!rail_is_data(din[b])) complete = 1'b0;
      if (din[b] != NULL)        is_null  = 1'b0;
      if (din[b] == ILL)         illegal  = 1'b1;
    end
  end

endmodule

// File: rtl/merge_arb.sv
// Two-input, four-phase, two-rail merge with round-robin arbitration.
// All outputs are registered, and only one grant is in flight at a time.
module merge_arb
  import merge_arb_pkg::*;
#(
  parameter     ENC   = "TP",
  parameter int WIDTH = 1
) (
  input logic        clk,
  input logic        rst,
  merge_arb_if.slave bus
);

  if (ENC != "TP") begin : g_bad_enc
    $error("merge_arb: only the TP two-rail encoding is supported");
  end

  localparam logic [WIDTH-1:0][1:0] ALL_NULL = {WIDTH{NULL}};

  logic cmp0, nul0, ill0;
  logic cmp1, nul1, ill1;

  dr_stat #(.WIDTH(WIDTH)) u_stat0 (
    .din      (bus.in0),
    .complete (cmp0),
    .is_null  (nul0),
    .illegal  (ill0)
  );

  dr_stat #(.WIDTH(WIDTH)) u_stat1 (
    .din      (bus.in1),
    .complete (cmp1),
    .is_null  (nul1),
    .illegal  (ill1)
  );

  state_t                state_p0, state_p1;
  logic [WIDTH-1:0][1:0] out_p0,   out_p1;
  logic                  ack0_p0,  ack0_p1;
  logic                  ack1_p0,  ack1_p1;
  logic                  grant_p0, grant_p1;
  logic                  prio_p0,  prio_p1;
  logic                  err_p0,   err_p1;
  logic                  gnt_null;

  assign gnt_null = grant_p1 ? nul1 : nul0;

  // Next-state stage: arbitration, forwarding and return-to-zero
  always_comb begin
    state_p0 = state_p1;
    out_p0   = out_p1;
    ack0_p0  = ack0_p1;
    ack1_p0  = ack1_p1;
    grant_p0 = grant_p1;
    prio_p0  = prio_p1;
    err_p0   = err_p1;
    case (state_p1)
      IDLE: begin
        out_p0  = ALL_NULL;
        ack0_p0 = 1'b0;
        ack1_p0 = 1'b0;
        if (ill0 || ill1) err_p0 = 1'b1;
        // On a tie, prio names the channel that wins
        if (cmp0 && (!cmp1 || !prio_p1)) begin
          grant_p0 = 1'b0;
          out_p0   = bus.in0;
          state_p0 = FWD;
        end else if (cmp1) begin
          grant_p0 = 1'b1;
          out_p0   = bus.in1;
          state_p0 = FWD;
        end
      end
      FWD: begin
        if (bus.ack_i) begin
          out_p0 = ALL_NULL;
          if (grant_p1) ack1_p0 = 1'b1;
          else          ack0_p0 = 1'b1;
          state_p0 = RTZ;
        end
      end
      RTZ: begin
        if (gnt_null && !bus.ack_i) begin
          ack0_p0  = 1'b0;
          ack1_p0  = 1'b0;
          prio_p0  = ~grant_p1;
          state_p0 = IDLE;
        end
      end
      default: begin
        out_p0   = ALL_NULL;
        ack0_p0  = 1'b0;
        ack1_p0  = 1'b0;
        state_p0 = IDLE;
      end
    endcase
  end

  // Register stage: every output comes straight from a flop
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1 <= IDLE;
      out_p1   <= ALL_NULL;
      ack0_p1  <= 1'b0;
      ack1_p1  <= 1'b0;
      grant_p1 <= 1'b0;
      prio_p1  <= 1'b0;
      err_p1   <= 1'b0;
    end else begin
      state_p1 <= state_p0;
      out_p1   <= out_p0;
      ack0_p1  <= ack0_p0;
      ack1_p1  <= ack1_p0;
      grant_p1 <= grant_p0;
      prio_p1  <= prio_p0;
      err_p1   <= err_p0;
    end
  end

  assign bus.out    = out_p1;
  assign bus.ack_o0 = ack0_p1;
  assign bus.ack_o1 = ack1_p1;
  assign bus.err    = err_p1;

endmodule

// File: tb/tb_merge_arb.sv
// Directed bench for merge_arb at WIDTH=2; expected grants are queued when requests are driven.
// Each grant is then popped and checked through the full four-phase handshake.
module tb_merge_arb;
  import merge_arb_pkg::*;

  typedef struct packed {
    logic       ch;
    logic [3:0] data;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  exp_t sb[$];

  merge_arb_if #(.WIDTH(2)) bus ();

  merge_arb #(.ENC("TP"), .WIDTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_ch(input logic ch, input logic [3:0] val);
    if (ch) bus.in1 = val;
    else    bus.in0 = val;
  endtask

  // Wait for the next grant, pop its expectation and run the full handshake on it.
  task automatic serve(input string tag, input logic [3:0] rearm,
                       input bit glitch, input logic [3:0] gval);
    exp_t e;
    int   n;
    n = 0;
    while (bus.out === 4'b0000 && n < 8) begin
      tick();
      n++;
    end
    chk({tag, "_sb"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk({tag, "_lat"}, n, 32'd1);
    chk({tag, "_data"}, bus.out, e.data);
    chk({tag, "_acks_fwd"}, {bus.ack_o1, bus.ack_o0}, 2'b00);
    if (glitch) drive_ch(e.ch, gval);
    tick();
    chk({tag, "_hold"}, bus.out, e.data);
    bus.ack_i = 1'b1;
    tick();
    chk({tag, "_out_null"}, bus.out, 4'b0000);
    chk({tag, "_ack_set"}, {bus.ack_o1, bus.ack_o0}, e.ch ? 2'b10 : 2'b01);
    drive_ch(e.ch, 4'b0000);
    tick();
    chk({tag, "_ack_keep"}, {bus.ack_o1, bus.ack_o0}, e.ch ? 2'b10 : 2'b01);
    bus.ack_i = 1'b0;
    tick();
    chk({tag, "_ack_clr"}, {bus.ack_o1, bus.ack_o0}, 2'b00);
    if (rearm != 4'b0000) drive_ch(e.ch, rearm);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst       = 1'b1;
    bus.in0   = 4'b0000;
    bus.in1   = 4'b0000;
    bus.ack_i = 1'b0;
    tick();
    tick();
    chk("rst_out", bus.out, 4'b0000);
    chk("rst_ack0", bus.ack_o0, 1'b0);
    chk("rst_ack1", bus.ack_o1, 1'b0);
    chk("rst_err", bus.err, 1'b0);
    rst = 1'b0;
    tick();

    // Single request on channel 0
    bus.in0 = 4'b0110;
    sb.push_back('{ch: 1'b0, data: 4'b0110});
    serve("single", 4'b0000, 1'b0, 4'b0000);

    // Simultaneous requests straight after reset: channel 0 wins, then channel 1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.in0 = 4'b1010;
    bus.in1 = 4'b0101;
    sb.push_back('{ch: 1'b0, data: 4'b1010});
    sb.push_back('{ch: 1'b1, data: 4'b0101});
    serve("simul_a", 4'b0000, 1'b0, 4'b0000);
    serve("simul_b", 4'b0000, 1'b0, 4'b0000);

    // Fairness with both channels continuously re-requesting
    bus.in0 = 4'b1001;
    bus.in1 = 4'b0110;
    sb.push_back('{ch: 1'b0, data: 4'b1001});
    sb.push_back('{ch: 1'b1, data: 4'b0110});
    sb.push_back('{ch: 1'b0, data: 4'b1001});
    sb.push_back('{ch: 1'b1, data: 4'b0110});
    serve("fair_0", 4'b1001, 1'b0, 4'b0000);
    serve("fair_1", 4'b0110, 1'b0, 4'b0000);
    serve("fair_2", 4'b0000, 1'b0, 4'b0000);
    serve("fair_3", 4'b0000, 1'b0, 4'b0000);

    // Partial word is not granted
    bus.in1 = 4'b0010;
    tick();
    tick();
    chk("partial_out", bus.out, 4'b0000);
    chk("partial_acks", {bus.ack_o1, bus.ack_o0}, 2'b00);
    chk("partial_err", bus.err, 1'b0);

    // Illegal word is not granted and raises a sticky error
    bus.in1 = 4'b1101;
    tick();
    tick();
    chk("illegal_out", bus.out, 4'b0000);
    chk("illegal_acks", {bus.ack_o1, bus.ack_o0}, 2'b00);
    chk("illegal_err", bus.err, 1'b1);
    bus.in1 = 4'b0000;
    tick();
    tick();
    tick();
    chk("err_sticky", bus.err, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("err_cleared", bus.err, 1'b0);

    // Reset while in return-to-zero abandons the grant, then the request is re-served
    bus.in0 = 4'b0110;
    sb.push_back('{ch: 1'b0, data: 4'b0110});
    tick();
    chk("abort_fwd", bus.out, 4'b0110);
    bus.ack_i = 1'b1;
    tick();
    chk("abort_rtz_ack", bus.ack_o0, 1'b1);
    rst = 1'b1;
    tick();
    chk("abort_acks", {bus.ack_o1, bus.ack_o0}, 2'b00);
    chk("abort_out", bus.out, 4'b0000);
    chk("abort_state", dut.state_p1, IDLE);
    chk("abort_prio", dut.prio_p1, 1'b0);
    rst = 1'b0;
    bus.ack_i = 1'b0;
    serve("rearb", 4'b0000, 1'b0, 4'b0000);

    // Changing the granted input during FWD does not disturb out
    bus.in0 = 4'b1001;
    sb.push_back('{ch: 1'b0, data: 4'b1001});
    serve("stable", 4'b0000, 1'b1, 4'b0101);

    chk("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
